// File: rtl/vga_timing_gen_pkg.sv
// Shared timing definitions for the VGA timing generator.
// Holds the 640x480@60 default segments, the derived totals and sync windows,
// and small helpers used by the axis counters and the top level.
package vga_timing_gen_pkg;

  typedef logic [9:0] vga_coord_t;

  localparam int MAX_AXIS_TOTAL = 1024;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Length of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  // Pin level for a sync output given whether the counter sits in its sync window.
  function automatic logic sync_level(input logic in_window, input logic active_low);
    return in_window ^ active_low;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-stream interface driven by the VGA timing generator.
// The generator owns the master side; renderers, sprite blocks and the
// connector logic attach through the slave side.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  vga_coord_t  DrawX;
  vga_coord_t  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen_sync_axis.sv
// One axis of the VGA raster: a wrapping counter with an advance enable.
// Used once for pixels within a line and once for lines within a frame.
// The wrap/visible/sync-window flags are plain decodes of the current count;
// the top level registers everything that leaves the block.
module vga_timing_gen_sync_axis
  import vga_timing_gen_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       en,
  output vga_coord_t count,
  output logic       wrap,
  output logic       visible,
  output logic       sync_win
);

  localparam int TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int SYNC_START = VISIBLE + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;

  // A 10-bit counter cannot represent an axis longer than 1024 positions.
  if (TOTAL < 1 || TOTAL > MAX_AXIS_TOTAL) begin : g_bad_total
    $error("vga_timing_gen_sync_axis: axis total must be within 1..1024");
  end

  localparam vga_coord_t LAST = vga_coord_t'(TOTAL - 1);

  // One extra bit keeps window bounds equal to 1024 from truncating to zero.
  logic [10:0] count_wide;

  assign count_wide = {1'b0, count};
  assign wrap       = (count == LAST);
  assign visible    = (count_wide < 11'(VISIBLE));
  assign sync_win   = (count_wide >= 11'(SYNC_START)) && (count_wide < 11'(SYNC_END));

  // Advance on enable, returning to zero after the last position of the axis.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: source end of the pixel stream.
// Produces DrawX/DrawY/blank/frame_start for renderers and hs/vs for the
// connector, all registered one cycle behind the raster counters.
// Optional feature macro: VGA_FRAME_COUNT_EN enables the 8-bit frame counter;
// without it frame_count is constant zero and no counter is built.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                vga_clk,
  input  logic                reset,
  vga_timing_gen_if.master    pix
);

  // Idle sync level equals the active-low flag: high when sync pulses go low.
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  vga_coord_t h_count;
  vga_coord_t v_count;
  logic       h_wrap;
  logic       h_visible;
  logic       h_sync_win;
  logic       v_wrap;
  logic       v_visible;
  logic       v_sync_win;

  vga_timing_gen_sync_axis #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .en       (1'b1),
    .count    (h_count),
    .wrap     (h_wrap),
    .visible  (h_visible),
    .sync_win (h_sync_win)
  );

  vga_timing_gen_sync_axis #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .en       (h_wrap),
    .count    (v_count),
    .wrap     (v_wrap),
    .visible  (v_visible),
    .sync_win (v_sync_win)
  );

  // Register the decoded raster position so every output shares one cycle of latency.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pix.DrawX       <= '0;
      pix.DrawY       <= '0;
      pix.blank       <= 1'b0;
      pix.hs          <= SYNC_IDLE;
      pix.vs          <= SYNC_IDLE;
      pix.frame_start <= 1'b0;
    end else begin
      pix.DrawX       <= h_count;
      pix.DrawY       <= v_count;
      pix.blank       <= h_visible && v_visible;
      pix.hs          <= sync_level(h_sync_win, SYNC_ACTIVE_LOW);
      pix.vs          <= sync_level(v_sync_win, SYNC_ACTIVE_LOW);
      pix.frame_start <= (h_count == '0) && (v_count == '0);
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic       frame_wrap_q;
  logic [7:0] frame_count_q;

  // Note the raster wrap, then bump the count one edge later alongside frame_start.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_wrap_q  <= 1'b0;
      frame_count_q <= 8'h00;
    end else begin
      frame_wrap_q <= h_wrap && v_wrap;
      if (frame_wrap_q) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign pix.frame_count = frame_count_q;
`else
  logic unused_v_wrap;

  assign unused_v_wrap   = v_wrap;
  assign pix.frame_count = 8'h00;
`endif

endmodule
